// File: rtl/sram_arbiter.sv
// Three-way arbiter (ROM initializer, screen fetch, CPU) for one asynchronous SRAM; fixed 4-cycle access.
// Optional feature: define SRAM_ARB_STARVE_EN to let a CPU starved by screen fetches jump ahead of scr.
module sram_arbiter #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 19
) (
  input  logic              clk28,
  input  logic              rst_n,
  input  logic              init_req,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic [DATA_W-1:0] init_wdata,
  output logic              init_ack,
  input  logic              scr_req,
  input  logic [ADDR_W-1:0] scr_addr,
  output logic              scr_ack,
  input  logic              cpu_req,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] sram_a,
  input  logic [DATA_W-1:0] sram_din,
  output logic [DATA_W-1:0] sram_dout,
  output logic              sram_dout_en,
  output logic              n_vrd,
  output logic              n_vwr,
  output logic              busy
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] STROBE = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  logic [1:0]        state;
  logic [2:0]        grant;   // one-hot {cpu, scr, init}
  logic [2:0]        pick;
  logic              wr;
  logic              turn;
  logic              access;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

`ifdef SRAM_ARB_STARVE_EN
  logic [1:0] starve;

  function automatic logic [1:0] sat_inc(input logic [1:0] v);
    return (v == 2'd3) ? v : v + 2'd1;
  endfunction

  always_comb begin
    pick = 3'b000;
    if (init_req)                     pick = 3'b001;
    else if (cpu_req && starve == 2'd3) pick = 3'b100;
    else if (scr_req)                 pick = 3'b010;
    else if (cpu_req)                 pick = 3'b100;
  end

  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      starve <= 2'd0;
    end else if (!cpu_req) begin
      starve <= 2'd0;
    end else if (state == IDLE && !turn) begin
      if (pick[2])      starve <= 2'd0;
      else if (pick[1]) starve <= sat_inc(starve);
    end
  end
`else
  always_comb begin
    pick = 3'b000;
    if (init_req)     pick = 3'b001;
    else if (scr_req) pick = 3'b010;
    else if (cpu_req) pick = 3'b100;
  end
`endif

  // The IDLE cycle after DONE is a turnaround: the acked requester is still
  // dropping its req, and granting nobody there keeps the priority order strict.
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      grant   <= 3'b000;
      wr      <= 1'b0;
      turn    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata   <= '0;
    end else begin
      turn <= (state == DONE);
      case (state)
        IDLE: begin
          if (!turn && pick != 3'b000) begin
            state   <= SETUP;
            grant   <= pick;
            wr      <= pick[0] || (pick[2] && cpu_wr);
            addr_q  <= pick[0] ? init_addr : (pick[1] ? scr_addr : cpu_addr);
            wdata_q <= pick[0] ? init_wdata : cpu_wdata;
          end
        end
        SETUP:  state <= STROBE;
        STROBE: begin
          state <= DONE;
          if (!wr) rdata <= sram_din;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign access       = (state == SETUP) || (state == STROBE);
  assign sram_a       = addr_q;
  assign sram_dout    = wdata_q;
  assign sram_dout_en = access && wr;
  assign n_vrd        = !(access && !wr);
  assign n_vwr        = !((state == STROBE) && wr);
  assign init_ack     = (state == DONE) && grant[0];
  assign scr_ack      = (state == DONE) && grant[1];
  assign cpu_ack      = (state == DONE) && grant[2];
  assign busy         = (state != IDLE);

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter: agents queue expected transactions, a monitor checks every ack
// against a reference memory updated in completion order. Honours SRAM_ARB_STARVE_EN.
module tb_sram_arbiter;

  logic        clk28 = 1'b0;
  logic        rst_n = 1'b0;
  logic        init_req = 1'b0;
  logic [18:0] init_addr = '0;
  logic [7:0]  init_wdata = '0;
  logic        init_ack;
  logic        scr_req = 1'b0;
  logic [18:0] scr_addr = '0;
  logic        scr_ack;
  logic        cpu_req = 1'b0;
  logic        cpu_wr = 1'b0;
  logic [18:0] cpu_addr = '0;
  logic [7:0]  cpu_wdata = '0;
  logic        cpu_ack;
  logic [7:0]  rdata;
  logic [18:0] sram_a;
  logic [7:0]  sram_din = '0;
  logic [7:0]  sram_dout;
  logic        sram_dout_en;
  logic        n_vrd;
  logic        n_vwr;
  logic        busy;

  always #5 clk28 = ~clk28;

  sram_arbiter dut (
    .clk28(clk28), .rst_n(rst_n),
    .init_req(init_req), .init_addr(init_addr), .init_wdata(init_wdata), .init_ack(init_ack),
    .scr_req(scr_req), .scr_addr(scr_addr), .scr_ack(scr_ack),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack),
    .rdata(rdata), .sram_a(sram_a), .sram_din(sram_din), .sram_dout(sram_dout),
    .sram_dout_en(sram_dout_en), .n_vrd(n_vrd), .n_vwr(n_vwr), .busy(busy)
  );

  typedef struct packed {
    logic        wr;
    logic [18:0] addr;
    logic [7:0]  wdata;
  } txn_t;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  txn_t q_init[$];
  txn_t q_scr[$];
  txn_t q_cpu[$];
  logic [7:0] dev_mem[int];
  logic [7:0] ref_mem[int];
  int   ack_log[$];
  int   ack_cyc[$];
  int   ack_cnt[3];
  int   busy_cnt = 0, rd_cnt = 0, en_cnt = 0, vwr_cnt = 0;
  logic vwr_bad = 1'b0;
  logic [7:0] bus_wdata = '0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input string msg);
    checks++;
    errors++;
    $display("FAIL %s: %s", name, msg);
  endtask

  function automatic logic [7:0] dflt(input logic [18:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  function logic [7:0] dev_rd(input logic [18:0] a);
    return dev_mem.exists(int'(a)) ? dev_mem[int'(a)] : dflt(a);
  endfunction

  function logic [7:0] ref_rd(input logic [18:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : dflt(a);
  endfunction

  function logic ack_of(input int id);
    return (id == 0) ? init_ack : ((id == 1) ? scr_ack : cpu_ack);
  endfunction

  // SRAM device model and cycle counter
  initial forever begin
    @(posedge clk28);
    cyc++;
    if (rst_n && !n_vwr) dev_mem[int'(sram_a)] = sram_dout;
  end

  initial forever begin
    @(negedge clk28);
    sram_din = dev_rd(sram_a);
  end

  // Monitor: protocol checks every cycle, scoreboard pop on every ack
  initial begin : monitor
    int   id;
    txn_t e;
    bit   have;
    forever begin
      @(negedge clk28);
      if (!rst_n) begin
        busy_cnt = 0; rd_cnt = 0; en_cnt = 0; vwr_cnt = 0; vwr_bad = 1'b0;
      end else if (!busy) begin
        check("idle_bus", int'({n_vrd, n_vwr, sram_dout_en}), 6);
        check("idle_acks", int'({init_ack, scr_ack, cpu_ack}), 0);
        busy_cnt = 0; rd_cnt = 0; en_cnt = 0; vwr_cnt = 0; vwr_bad = 1'b0;
      end else begin
        busy_cnt++;
        check("rd_wr_overlap", int'(!n_vrd && sram_dout_en), 0);
        if (!n_vrd) rd_cnt++;
        if (sram_dout_en) en_cnt++;
        if (!n_vwr) begin
          vwr_cnt++;
          bus_wdata = sram_dout;
          if (en_cnt != 2) vwr_bad = 1'b1;
        end
        if (init_ack || scr_ack || cpu_ack) begin
          check("one_ack", int'(init_ack) + int'(scr_ack) + int'(cpu_ack), 1);
          id = init_ack ? 0 : (scr_ack ? 1 : 2);
          ack_cnt[id]++;
          ack_log.push_back(id);
          ack_cyc.push_back(cyc);
          check("ack_in_4th_cycle", busy_cnt, 3);
          check("done_strobes_off", int'({n_vrd, n_vwr, sram_dout_en}), 6);
          have = 1'b1;
          case (id)
            0: if (q_init.size() > 0) e = q_init.pop_front(); else have = 1'b0;
            1: if (q_scr.size() > 0)  e = q_scr.pop_front();  else have = 1'b0;
            default: if (q_cpu.size() > 0) e = q_cpu.pop_front(); else have = 1'b0;
          endcase
          if (!have) begin
            fail("unexpected_ack", $sformatf("requester %0d acked at cycle %0d, expected no ack", id, cyc));
          end else begin
            check("ack_addr", int'(sram_a), int'(e.addr));
            if (e.wr) begin
              check("wr_dout_en_cycles", en_cnt, 2);
              check("wr_nvwr_cycles", vwr_cnt, 1);
              check("wr_nvwr_in_strobe", int'(vwr_bad), 0);
              check("wr_nvrd_idle", rd_cnt, 0);
              check("wr_data", int'(bus_wdata), int'(e.wdata));
              ref_mem[int'(e.addr)] = e.wdata;
            end else begin
              check("rd_nvrd_cycles", rd_cnt, 2);
              check("rd_no_write", en_cnt + vwr_cnt, 0);
              check("rd_data", int'(rdata), int'(ref_rd(e.addr)));
            end
          end
        end
      end
    end
  end

  task automatic wait_ack(input int id);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk28);
      if (ack_of(id)) return;
    end
    fail("ack_timeout", $sformatf("requester %0d got no ack within 300 cycles, expected one", id));
  endtask

  task automatic init_xfer(input logic [18:0] a, input logic [7:0] d);
    init_addr = a; init_wdata = d;
    q_init.push_back({1'b1, a, d});
    init_req = 1'b1;
    wait_ack(0);
    init_req = 1'b0;
  endtask

  task automatic scr_hold(input int n, input logic [18:0] a);
    scr_addr = a;
    scr_req = 1'b1;
    for (int i = 0; i < n; i++) begin
      q_scr.push_back({1'b0, a, 8'h00});
      wait_ack(1);
    end
    scr_req = 1'b0;
  endtask

  task automatic cpu_xfer(input logic w, input logic [18:0] a, input logic [7:0] d);
    cpu_wr = w; cpu_addr = a; cpu_wdata = d;
    q_cpu.push_back({w, a, d});
    cpu_req = 1'b1;
    wait_ack(2);
    cpu_req = 1'b0;
  endtask

  function automatic logic [18:0] rand_addr();
    return 19'h08000 + 19'($urandom_range(0, 7));
  endfunction

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int base;
    int bc;
    int found;
    #3;
    check("rst_ctrl", int'({n_vrd, n_vwr, sram_dout_en, busy, init_ack, scr_ack, cpu_ack}), 7'b1100000);
    check("rst_sram_a", int'(sram_a), 0);
    check("rst_rdata", int'(rdata), 0);
    check("rst_dout", int'(sram_dout), 0);
    repeat (2) @(negedge clk28);
    rst_n = 1'b1;
    repeat (2) @(negedge clk28);

    // cpu read of 0x7C000 holding 0xA5
    dev_mem[int'(19'h7C000)] = 8'hA5;
    ref_mem[int'(19'h7C000)] = 8'hA5;
    cpu_xfer(1'b0, 19'h7C000, 8'h00);
    check("cpu_read_a5", int'(rdata), 8'hA5);

    // cpu write of 0x3C to 0x12345; rdata must keep the last read
    cpu_xfer(1'b1, 19'h12345, 8'h3C);
    @(negedge clk28);
    check("cpu_write_mem", int'(dev_rd(19'h12345)), 8'h3C);
    check("rdata_hold", int'(rdata), 8'hA5);

    // simultaneous requests
    repeat (2) @(negedge clk28);
    ack_log.delete(); ack_cyc.delete();
    fork
      init_xfer(19'h00010, 8'h11);
      scr_hold(1, 19'h00020);
      cpu_xfer(1'b0, 19'h00010, 8'h00);
    join
    @(negedge clk28);
    check("order_count", ack_log.size(), 3);
    if (ack_log.size() == 3) begin
      check("order_0_init", ack_log[0], 0);
      check("order_1_scr", ack_log[1], 1);
      check("order_2_cpu", ack_log[2], 2);
      check("spacing_01", ack_cyc[1] - ack_cyc[0], 5);
      check("spacing_12", ack_cyc[2] - ack_cyc[1], 5);
    end
    check("cpu_reads_init_data", int'(rdata), 8'h11);

    // cpu request withdrawn while scr is served
    repeat (2) @(negedge clk28);
    base = ack_cnt[2];
    fork
      scr_hold(1, 19'h00400);
      begin
        cpu_wr = 1'b0; cpu_addr = 19'h00401; cpu_req = 1'b1;
        for (int i = 0; i < 50; i++) begin
          @(negedge clk28);
          if (scr_ack) break;
        end
        cpu_req = 1'b0;
      end
    join
    bc = 0;
    repeat (12) begin
      @(negedge clk28);
      if (busy) bc++;
    end
    check("dropped_cpu_no_ack", ack_cnt[2] - base, 0);
    check("dropped_cpu_no_access", bc, 0);

    // scr held continuously against a waiting cpu
    ack_log.delete(); ack_cyc.delete();
`ifdef SRAM_ARB_STARVE_EN
    fork
      cpu_xfer(1'b0, 19'h00500, 8'h00);
      scr_hold(4, 19'h00600);
      begin
        found = 0;
        for (int i = 0; i < 100 && found < 3; i++) begin
          @(negedge clk28);
          if (scr_ack) found++;
        end
        init_xfer(19'h00601, 8'h77);
      end
    join
    @(negedge clk28);
    check("starve_count", ack_log.size(), 6);
    if (ack_log.size() == 6) begin
      check("starve_0_scr", ack_log[0], 1);
      check("starve_1_scr", ack_log[1], 1);
      check("starve_2_scr", ack_log[2], 1);
      check("starve_3_init_wins", ack_log[3], 0);
      check("starve_4_cpu", ack_log[4], 2);
      check("starve_5_scr", ack_log[5], 1);
    end
`else
    base = ack_cnt[2];
    fork
      cpu_xfer(1'b0, 19'h00500, 8'h00);
      begin
        scr_hold(5, 19'h00600);
        check("cpu_starved", ack_cnt[2] - base, 0);
      end
    join
    @(negedge clk28);
    check("strict_count", ack_log.size(), 6);
    if (ack_log.size() == 6) begin
      for (int i = 0; i < 5; i++) check("strict_scr_first", ack_log[i], 1);
      check("strict_cpu_last", ack_log[5], 2);
    end
`endif

    // reset during STROBE of a write
    repeat (2) @(negedge clk28);
    base = ack_cnt[2];
    cpu_wr = 1'b1; cpu_addr = 19'h00700; cpu_wdata = 8'hEE; cpu_req = 1'b1;
    found = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk28);
      if (!n_vwr) begin
        found = 1;
        break;
      end
    end
    if (found == 0) fail("strobe_seen", "write strobe never appeared, expected one");
    #1 rst_n = 1'b0;
    #1;
    check("abort_nvwr", int'(n_vwr), 1);
    check("abort_dout_en", int'(sram_dout_en), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_nvrd", int'(n_vrd), 1);
    check("abort_acks", int'({init_ack, scr_ack, cpu_ack}), 0);
    check("abort_sram_a", int'(sram_a), 0);
    check("abort_rdata", int'(rdata), 0);
    cpu_req = 1'b0;
    repeat (2) @(negedge clk28);
    rst_n = 1'b1;
    bc = 0;
    repeat (6) begin
      @(negedge clk28);
      if (busy) bc++;
    end
    check("abort_no_ack", ack_cnt[2] - base, 0);
    check("abort_idle_after", bc, 0);
    check("abort_mem_untouched", int'(dev_rd(19'h00700)), int'(ref_rd(19'h00700)));

    // randomized traffic against the reference memory
    for (int r = 0; r < 40; r++) begin
      fork
        begin
          if ($urandom_range(0, 2) == 0) begin
            repeat ($urandom_range(0, 3)) @(negedge clk28);
            init_xfer(rand_addr(), 8'($urandom));
          end
        end
        begin
          if ($urandom_range(0, 1) == 0) begin
            repeat ($urandom_range(0, 3)) @(negedge clk28);
            scr_hold(1, rand_addr());
          end
        end
        begin
          if ($urandom_range(0, 1) == 0) begin
            repeat ($urandom_range(0, 3)) @(negedge clk28);
            cpu_xfer(1'($urandom), rand_addr(), 8'($urandom));
          end
        end
      join
      @(negedge clk28);
    end
    repeat (4) @(negedge clk28);
    check("queues_drained", q_init.size() + q_scr.size() + q_cpu.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have port clk28, input, 1 bit: system clock (28 MHz); one clock domain only.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have ports init_req in 1, init_addr in 19, init_wdata in 8, init_ack out 1: write-only requester for the ROM-to-RAM initializer.
REQ-004 SHALL have ports scr_req in 1, scr_addr in 19, scr_ack out 1: read-only requester for the screen fetch.
REQ-005 SHALL have ports cpu_req in 1, cpu_wr in 1, cpu_addr in 19, cpu_wdata in 8, cpu_ack out 1: read/write requester for the CPU.
REQ-006 SHALL have port rdata, output, 8 bits: read data; valid in the cycle when scr_ack or cpu_ack is high.
REQ-007 SHALL have ports sram_a out 19, sram_din in 8, sram_dout out 8, sram_dout_en out 1, n_vrd out 1, n_vwr out 1: external SRAM bus.
REQ-008 SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-009 SHALL be an FSM with states IDLE, SETUP, STROBE and DONE; each access takes exactly 4 clk28 cycles, from the IDLE grant to the DONE exit.
REQ-010 In IDLE with any request high, SHALL grant one requester, latch its addr, wdata and direction (init is always a write; scr is always a read), and go to SETUP; with no request it SHALL stay in IDLE.
REQ-011 Priority SHALL be init > scr > cpu, subject to REQ-018.
REQ-012 In SETUP and STROBE, sram_a SHALL equal the latched address; for reads n_vrd=0; for writes sram_dout_en=1 and sram_dout=latched wdata.
REQ-013 n_vwr SHALL be 0 only in STROBE of a write; n_vrd=0 and sram_dout_en=1 SHALL never occur in the same cycle.
REQ-014 At the end of STROBE of a read, SHALL register sram_din into rdata; rdata SHALL hold that value until the next read completes.
REQ-015 In DONE: all strobes inactive, sram_dout_en=0, sram_a held; the granted requester's ack high for exactly this one cycle; next state IDLE.
REQ-016 A requester SHALL hold req and its parameters stable until its ack; the arbiter SHALL ignore the just-acked requester in the IDLE cycle that follows DONE.
REQ-017 A request deasserted before its grant SHALL be dropped silently; once granted, the access SHALL complete even if req falls.
REQ-018 A 2-bit starvation counter SHALL increment, saturating at 3, on each scr grant made while cpu_req=1; it SHALL clear on a cpu grant or whenever cpu_req=0.
REQ-019 On simultaneous requests, init SHALL always win, even over a starved cpu.

Reset
REQ-020 While rst_n=0, all outputs SHALL take their reset values immediately (asynchronously): state IDLE, n_vrd=1, n_vwr=1, sram_dout_en=0, sram_dout=0, sram_a=0, rdata=0, all acks 0, busy=0, counter 0.
REQ-021 Reset during SETUP or STROBE SHALL abort the access with no ack issued; after release, the FSM SHALL re-arbitrate from IDLE.

Configuration
REQ-022 With macro SRAM_ARB_STARVE_EN defined, a counter value of 3 with cpu_req=1 and init_req=0 SHALL give the next grant to cpu ahead of scr.
REQ-023 Without SRAM_ARB_STARVE_EN, priority SHALL be strict init > scr > cpu, and the counter logic SHALL be absent.

Verification
REQ-024 The bench SHALL cover: cpu read of addr 0x7C000 with sram_din=0xA5 -> n_vrd low for 2 cycles, cpu_ack in the 4th cycle with rdata=0xA5.
REQ-025 The bench SHALL cover: cpu write of 0x3C to 0x12345 -> sram_dout_en high for 2 cycles, n_vwr low only in STROBE, n_vrd stays 1.
REQ-026 The bench SHALL cover: init_req, scr_req and cpu_req all raised in the same cycle -> grant order init, scr, then cpu, with 4 cycles per access and no gaps other than the IDLE cycles.
REQ-027 The bench SHALL cover: scr_req held high continuously with cpu_req=1 -> with SRAM_ARB_STARVE_EN, the cpu is served after 3 scr accesses; without it, the cpu is never served.
REQ-028 The bench SHALL cover: rst_n pulled low during STROBE of a write -> n_vwr=1 and sram_dout_en=0 in the same cycle, no ack, and busy=0.
REQ-029 The bench SHALL cover: cpu_req dropped in IDLE while scr is being served -> no cpu access occurs and cpu_ack stays 0.
